// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DC_WAIT = 2'd1,
    MD_BUSY = 2'd2
  } state_e;

  localparam int MD_LATENCY_DEF = 32;
  localparam int PERF_W_DEF     = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: D-cache freeze > mul/div > redirect > load-use.
// Performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int PERF_W     = PERF_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr,
  input  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr,
  input  logic                  ID_Rs1_Used,
  input  logic                  ID_Rs2_Used,
  input  logic [ADDR_WIDTH-1:0] EX_Rd_Addr,
  input  logic                  EX_Mem_r,
  input  logic                  EX_Redirect,
  input  logic                  EX_MulDiv,
  input  logic                  MEM_DC_Req,
  input  logic                  MEM_DC_Ready,
  output logic                  PC_Stall,
  output logic                  IF_ID_Stall,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Stall,
  output logic                  ID_EX_Flush,
  output logic                  EX_MEM_Stall,
  output logic                  EX_MEM_Flush,
  output logic                  MEM_WB_Flush,
  output logic [PERF_W-1:0]     Stall_Cnt,
  output logic [PERF_W-1:0]     Flush_Cnt,
  output state_e                dbg_state
);

  localparam int              MD_W    = $clog2(MD_LATENCY);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 2);

  state_e          state, state_nx;
  logic [MD_W-1:0] md_cnt, md_cnt_nx;
  logic            freeze, load_use, md_active;

  assign freeze   = MEM_DC_Req && !MEM_DC_Ready;
  assign load_use = EX_Mem_r && (EX_Rd_Addr != '0) &&
                    ((ID_Rs1_Used && (ID_Rs1_Addr == EX_Rd_Addr)) ||
                     (ID_Rs2_Used && (ID_Rs2_Addr == EX_Rd_Addr)));
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nx;
      md_cnt <= md_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    md_cnt_nx    = md_cnt;
    md_active    = 1'b0;
    PC_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Stall  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Stall = 1'b0;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Flush = 1'b0;

    if (freeze) begin
      // A frozen mul/div stays in MD_BUSY with md_cnt paused.
      PC_Stall     = 1'b1;
      IF_ID_Stall  = 1'b1;
      ID_EX_Stall  = 1'b1;
      EX_MEM_Stall = 1'b1;
      MEM_WB_Flush = 1'b1;
      if (state != MD_BUSY) state_nx = DC_WAIT;
    end else begin
      if (state == MD_BUSY) begin
        if (md_cnt != '0) begin
          md_active = 1'b1;
          md_cnt_nx = md_cnt - 1'b1;
        end else begin
          state_nx = RUN;
        end
      end else if (EX_MulDiv) begin
        // DC_WAIT releasing this cycle behaves as RUN.
        md_active = 1'b1;
        state_nx  = MD_BUSY;
        md_cnt_nx = MD_LOAD;
      end else begin
        state_nx = RUN;
      end

      if (md_active) begin
        PC_Stall     = 1'b1;
        IF_ID_Stall  = 1'b1;
        ID_EX_Stall  = 1'b1;
        EX_MEM_Flush = 1'b1;
      end else if (EX_Redirect) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (load_use) begin
        PC_Stall    = 1'b1;
        IF_ID_Stall = 1'b1;
        ID_EX_Flush = 1'b1;
      end
    end

    if (rst) begin
      PC_Stall     = 1'b0;
      IF_ID_Stall  = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Stall  = 1'b0;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Stall = 1'b0;
      EX_MEM_Flush = 1'b0;
      MEM_WB_Flush = 1'b0;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (PC_Stall),
    .cnt (Stall_Cnt)
  );

  pipe_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (IF_ID_Flush),
    .cnt (Flush_Cnt)
  );
`else
  assign Stall_Cnt = '0;
  assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an expected-output queue and negedge monitor.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int PW = 4;
  localparam int W  = 10;

  localparam logic [7:0] PCS = 8'h80, IFS = 8'h40, IFF = 8'h20, IDS = 8'h10;
  localparam logic [7:0] IDF = 8'h08, EXS = 8'h04, EXF = 8'h02, WBF = 8'h01;
  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] FRZ  = PCS | IFS | IDS | EXS | WBF;
  localparam logic [7:0] MDS  = PCS | IFS | IDS | EXF;
  localparam logic [7:0] RDR  = IFF | IDF;
  localparam logic [7:0] LU   = PCS | IFS | IDF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] rs1, rs2, rd;
  logic          rs1u, rs2u, mem_r, redir, muldiv, dcreq, dcrdy;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, ex_mem_flush, mem_wb_flush;
  logic [PW-1:0] stall_cnt, flush_cnt;
  state_e        dbg_state;

  pipe_hazard_ctrl #(.ADDR_WIDTH(AW), .MD_LATENCY(4), .PERF_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_Rs1_Addr  (rs1),
    .ID_Rs2_Addr  (rs2),
    .ID_Rs1_Used  (rs1u),
    .ID_Rs2_Used  (rs2u),
    .EX_Rd_Addr   (rd),
    .EX_Mem_r     (mem_r),
    .EX_Redirect  (redir),
    .EX_MulDiv    (muldiv),
    .MEM_DC_Req   (dcreq),
    .MEM_DC_Ready (dcrdy),
    .PC_Stall     (pc_stall),
    .IF_ID_Stall  (if_id_stall),
    .IF_ID_Flush  (if_id_flush),
    .ID_EX_Stall  (id_ex_stall),
    .ID_EX_Flush  (id_ex_flush),
    .EX_MEM_Stall (ex_mem_stall),
    .EX_MEM_Flush (ex_mem_flush),
    .MEM_WB_Flush (mem_wb_flush),
    .Stall_Cnt    (stall_cnt),
    .Flush_Cnt    (flush_cnt),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         vec_valid = 1'b0;
  int           n_chk  = 0;
  int           n_pass = 0;

  function automatic logic [W-1:0] act_vec();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, ex_mem_flush, mem_wb_flush, 2'(dbg_state)};
  endfunction

  always @(negedge clk) begin
    if (vec_valid) begin
      logic [W-1:0] e, a;
      string        nm;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL queue_underflow: got empty queue, want an expected entry");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = act_vec();
        if (a === e) n_pass++;
        else $display("FAIL %s: got outs=%b state=%0d, want outs=%b state=%0d",
                      nm, a[9:2], a[1:0], e[9:2], e[1:0]);
      end
    end
  end

  // driver tasks
  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0;
    rs1u = 1'b0; rs2u = 1'b0; mem_r = 1'b0; redir = 1'b0;
    muldiv = 1'b0; dcreq = 1'b0; dcrdy = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [7:0] outs, input state_e st);
    exp_q.push_back({outs, 2'(st)});
    name_q.push_back(nm);
    vec_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    @(posedge clk);
    #1;
    // reset: outputs forced low even with a live miss
    cyc("reset_idle", NONE, RUN);
    dcreq = 1'b1;
    cyc("reset_masks_miss", NONE, RUN);
    idle();
    rst = 1'b0;
    check_val("stall_cnt_reset", int'(stall_cnt), 0);
    check_val("flush_cnt_reset", int'(flush_cnt), 0);

    // load-use
    mem_r = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1u = 1'b1;
    cyc("load_use_rs1", LU, RUN);
    idle();
    cyc("after_load_use", NONE, RUN);
    mem_r = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1u = 1'b1;
    cyc("load_use_x0", NONE, RUN);
    idle(); mem_r = 1'b1; rd = 5'd7; rs2 = 5'd7; rs2u = 1'b1;
    cyc("load_use_rs2", LU, RUN);
    idle(); mem_r = 1'b1; rd = 5'd7; rs1 = 5'd7; rs1u = 1'b0;
    cyc("load_use_unused", NONE, RUN);

    // redirect beats load-use
    idle(); mem_r = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1u = 1'b1; redir = 1'b1;
    cyc("redirect_vs_load_use", RDR, RUN);

    // 4-cycle D-cache miss
    idle(); dcreq = 1'b1;
    cyc("dc_miss_1", FRZ, RUN);
    cyc("dc_miss_2", FRZ, DC_WAIT);
    cyc("dc_miss_3", FRZ, DC_WAIT);
    cyc("dc_miss_4", FRZ, DC_WAIT);
    dcrdy = 1'b1;
    cyc("dc_release", NONE, DC_WAIT);
    idle();
    cyc("dc_after", NONE, RUN);

    // freeze masks redirect; redirect seen on release cycle
    dcreq = 1'b1; redir = 1'b1;
    cyc("redirect_masked", FRZ, RUN);
    dcrdy = 1'b1;
    cyc("redirect_on_release", RDR, DC_WAIT);
    idle();

    // mul/div, MD_LATENCY = 4
    muldiv = 1'b1;
    cyc("md_entry", MDS, RUN);
    cyc("md_busy_2", MDS, MD_BUSY);
    cyc("md_busy_1", MDS, MD_BUSY);
    cyc("md_release", NONE, MD_BUSY);
    idle();
    cyc("md_after", NONE, RUN);

    // mul/div with a 2-cycle miss in the middle
    muldiv = 1'b1;
    cyc("mdm_entry", MDS, RUN);
    cyc("mdm_busy", MDS, MD_BUSY);
    dcreq = 1'b1;
    cyc("mdm_freeze_1", FRZ, MD_BUSY);
    cyc("mdm_freeze_2", FRZ, MD_BUSY);
    dcreq = 1'b0;
    cyc("mdm_resume", MDS, MD_BUSY);
    cyc("mdm_release", NONE, MD_BUSY);
    idle();
    cyc("mdm_after", NONE, RUN);

    // reset while MD_BUSY with md_cnt = 2
    muldiv = 1'b1;
    cyc("mdr_entry", MDS, RUN);
    rst = 1'b1;
    cyc("mdr_reset", NONE, RUN);
    rst = 1'b0; idle();
    cyc("mdr_after_1", NONE, RUN);
    cyc("mdr_after_2", NONE, RUN);

    // perf counters: 20 stall cycles, then 3 flush cycles
    rst = 1'b1;
    cyc("perf_reset", NONE, RUN);
    rst = 1'b0; dcreq = 1'b1;
    cyc("perf_stall_first", FRZ, RUN);
    for (int i = 1; i < 20; i++) cyc("perf_stall", FRZ, DC_WAIT);
    dcrdy = 1'b1;
    cyc("perf_release", NONE, DC_WAIT);
    idle();
`ifdef PIPE_HAZARD_PERF_EN
    check_val("stall_cnt_sat", int'(stall_cnt), 15);
`else
    check_val("stall_cnt_off", int'(stall_cnt), 0);
`endif
    redir = 1'b1;
    for (int i = 0; i < 3; i++) cyc("perf_flush", RDR, RUN);
    idle();
    cyc("perf_idle", NONE, RUN);
`ifdef PIPE_HAZARD_PERF_EN
    check_val("flush_cnt", int'(flush_cnt), 3);
`else
    check_val("flush_cnt_off", int'(flush_cnt), 0);
`endif

    vec_valid = 1'b0;
    check_val("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
